// File: rtl/mcs4_rom_arbiter.sv
// rtl/mcs4_rom_arbiter.sv - shares one program memory between i4004 fetch and a host port
// Tracks the 8-phase 4004 cycle from sync; the CPU owns the A3 read slot, the host gets everything else.
module mcs4_rom_arbiter #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_run,
  output logic              cpu_rst,
  input  logic              cpu_sync,
  input  logic              cpu_cm_rom,
  input  logic [3:0]        cpu_dbus_o,
  output logic [3:0]        cpu_dbus_i,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_gnt,
  output logic              host_rvalid,
  output logic [DATA_W-1:0] host_rdata,
  output logic [15:0]       stall_cnt,
  output logic              sync_err
);

  localparam logic [2:0] PH_A1 = 3'd0;
  localparam logic [2:0] PH_A2 = 3'd1;
  localparam logic [2:0] PH_A3 = 3'd2;
  localparam logic [2:0] PH_M1 = 3'd3;
  localparam logic [2:0] PH_M2 = 3'd4;
  localparam logic [2:0] PH_X3 = 3'd7;

  logic [2:0]        phase;
  logic              locked_q;
  logic              locked;
  logic [3:0]        addr_lo;
  logic [3:0]        addr_mid;
  logic [3:0]        opa;
  logic              cpu_slot;
  logic [ADDR_W-1:0] cpu_addr;
  logic [ADDR_W-1:0] last_addr;
  logic [DATA_W-1:0] last_wdata;

  // Lock is void the moment the CPU is held in reset, not one cycle later.
  assign locked     = locked_q && !cpu_rst;
  assign cpu_slot   = locked && (phase == PH_A3) && cpu_cm_rom;
  assign host_gnt   = host_req && !cpu_slot;
  assign host_rdata = mem_rdata;
  assign mem_en     = cpu_slot || host_gnt;
  assign mem_we     = host_gnt && host_we;

  always_comb begin
    cpu_addr       = '0;
    cpu_addr[11:0] = {cpu_dbus_o, addr_mid, addr_lo};
  end

  // Idle cycles keep the last host address/data on the bus.
  always_comb begin
    mem_addr  = last_addr;
    mem_wdata = last_wdata;
    if (cpu_slot) begin
      mem_addr = cpu_addr;
    end else if (host_gnt) begin
      mem_addr  = host_addr;
      mem_wdata = host_wdata;
    end
  end

  always_comb begin
    cpu_dbus_i = 4'h0;
    if (locked && phase == PH_M1) begin
      cpu_dbus_i = mem_rdata[7:4];
    end else if (locked && phase == PH_M2) begin
      cpu_dbus_i = opa;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cpu_rst  <= 1'b1;
      locked_q <= 1'b0;
      phase    <= PH_A1;
      sync_err <= 1'b0;
      addr_lo  <= 4'h0;
      addr_mid <= 4'h0;
      opa      <= 4'h0;
    end else begin
      cpu_rst <= !cpu_run;
      if (cpu_rst) begin
        locked_q <= 1'b0;
      end else if (cpu_sync) begin
        locked_q <= 1'b1;
      end
      if (locked && cpu_sync && phase != PH_X3) begin
        sync_err <= 1'b1;
      end
      phase <= cpu_sync ? PH_A1 : phase + 3'd1;
      if (phase == PH_A1) begin
        addr_lo <= cpu_dbus_o;
      end
      if (phase == PH_A2) begin
        addr_mid <= cpu_dbus_o;
      end
      // OPA is captured from the CPU's own A3 read, so an M1 host access cannot clobber it.
      if (locked && phase == PH_M1) begin
        opa <= mem_rdata[3:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      host_rvalid <= 1'b0;
      stall_cnt   <= 16'h0000;
      last_addr   <= '0;
      last_wdata  <= '0;
    end else begin
      host_rvalid <= host_gnt && !host_we;
      if (host_req && !host_gnt && stall_cnt != 16'hFFFF) begin
        stall_cnt <= stall_cnt + 16'd1;
      end
      if (host_gnt) begin
        last_addr  <= host_addr;
        last_wdata <= host_wdata;
      end
    end
  end

endmodule

// File: tb/tb_mcs4_rom_arbiter.sv
// tb/tb_mcs4_rom_arbiter.sv - directed and randomized bench for mcs4_rom_arbiter
// An emulated 4004 and a behavioural memory drive the DUT; a rule-level model predicts every output.
module tb_mcs4_rom_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cpu_run;
  logic        cpu_rst;
  logic        cpu_sync;
  logic        cpu_cm_rom;
  logic [3:0]  cpu_dbus_o;
  logic [3:0]  cpu_dbus_i;
  logic        mem_en;
  logic        mem_we;
  logic [11:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  logic        host_req;
  logic        host_we;
  logic [11:0] host_addr;
  logic [7:0]  host_wdata;
  logic        host_gnt;
  logic        host_rvalid;
  logic [7:0]  host_rdata;
  logic [15:0] stall_cnt;
  logic        sync_err;

  always #5 clk = ~clk;

  mcs4_rom_arbiter #(.ADDR_W(12), .DATA_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .cpu_run(cpu_run), .cpu_rst(cpu_rst),
    .cpu_sync(cpu_sync), .cpu_cm_rom(cpu_cm_rom), .cpu_dbus_o(cpu_dbus_o),
    .cpu_dbus_i(cpu_dbus_i), .mem_en(mem_en), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
    .host_wdata(host_wdata), .host_gnt(host_gnt), .host_rvalid(host_rvalid),
    .host_rdata(host_rdata), .stall_cnt(stall_cnt), .sync_err(sync_err)
  );

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0]  dev_mem [0:4095];
  logic [7:0]  ref_mem [0:4095];

  // emulated CPU / stimulus state
  int          cpu_ph = 0;
  logic [11:0] fa = 12'h000;
  bit          rnd_mode = 0;
  bit          h_pend = 0;
  logic        s_en, s_we;
  logic [11:0] s_addr;
  logic [7:0]  s_wd;

  // reference model state
  bit          m_cpu_rst, m_locked, m_rvalid, m_sync_err;
  int          m_phase;
  logic [3:0]  m_alo, m_amid, m_opa;
  logic [7:0]  m_rd = 8'h00;
  logic [15:0] m_stall;
  logic [11:0] m_last_addr;
  logic [7:0]  m_last_wd;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    bit lk, slot, gnt;
    logic [11:0] ea;
    logic [7:0]  ewd;
    logic [3:0]  edb;
    lk   = m_locked && !m_cpu_rst;
    slot = lk && m_phase == 2 && cpu_cm_rom;
    gnt  = host_req && !slot;
    ea   = slot ? {cpu_dbus_o, m_amid, m_alo} : (gnt ? host_addr : m_last_addr);
    ewd  = gnt ? host_wdata : m_last_wd;
    edb  = (lk && m_phase == 3) ? m_rd[7:4] : ((lk && m_phase == 4) ? m_opa : 4'h0);
    chk("cpu_rst", cpu_rst, m_cpu_rst);
    chk("host_gnt", host_gnt, gnt);
    chk("mem_en", mem_en, slot || gnt);
    chk("mem_we", mem_we, gnt && host_we);
    chk("mem_addr", mem_addr, ea);
    chk("mem_wdata", mem_wdata, ewd);
    chk("cpu_dbus_i", cpu_dbus_i, edb);
    chk("host_rvalid", host_rvalid, m_rvalid);
    if (m_rvalid) chk("host_rdata", host_rdata, m_rd);
    chk("stall_cnt", stall_cnt, m_stall);
    chk("sync_err", sync_err, m_sync_err);
  endtask

  task automatic model_update();
    bit lk, slot, gnt;
    logic [11:0] a;
    logic [3:0]  opa_next;
    lk       = m_locked && !m_cpu_rst;
    slot     = lk && m_phase == 2 && cpu_cm_rom;
    gnt      = host_req && !slot;
    a        = slot ? {cpu_dbus_o, m_amid, m_alo} : host_addr;
    opa_next = (lk && m_phase == 3) ? m_rd[3:0] : m_opa;
    if (slot || (gnt && !host_we)) m_rd = ref_mem[a];
    if (gnt && host_we) ref_mem[a] = host_wdata;
    h_pend = host_req && !gnt;
    if (!rst_n) begin
      m_cpu_rst = 1; m_locked = 0; m_phase = 0; m_rvalid = 0; m_stall = 0;
      m_sync_err = 0; m_opa = 0; m_alo = 0; m_amid = 0;
      m_last_addr = 0; m_last_wd = 0;
    end else begin
      m_opa    = opa_next;
      m_rvalid = gnt && !host_we;
      if (host_req && !gnt && m_stall != 16'hFFFF) m_stall = m_stall + 16'd1;
      if (lk && cpu_sync && m_phase != 7) m_sync_err = 1;
      if (m_phase == 0) m_alo = cpu_dbus_o;
      if (m_phase == 1) m_amid = cpu_dbus_o;
      if (gnt) begin m_last_addr = host_addr; m_last_wd = host_wdata; end
      m_locked  = m_cpu_rst ? 0 : (cpu_sync ? 1 : m_locked);
      m_cpu_rst = !cpu_run;
      m_phase   = cpu_sync ? 0 : (m_phase + 1) % 8;
    end
  endtask

  task automatic step(input bit do_chk = 1);
    @(negedge clk);
    if (do_chk) check_outputs();
    s_en = mem_en; s_we = mem_we; s_addr = mem_addr; s_wd = mem_wdata;
    @(posedge clk);
    model_update();
    #1;
    if (s_en === 1'b1 && s_we === 1'b0) mem_rdata = dev_mem[s_addr];
    if (s_en === 1'b1 && s_we === 1'b1) dev_mem[s_addr] = s_wd;
    cpu_ph   = cpu_sync ? 0 : (cpu_ph + 1) % 8;
    cpu_sync = (cpu_ph == 7);
    if (rnd_mode) begin
      if (cpu_ph == 0) fa = 12'($urandom_range(0, 31));
      cpu_cm_rom = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 99) == 0) cpu_sync = 1'b1;
      cpu_run = ($urandom_range(0, 49) != 0);
      rst_n   = ($urandom_range(0, 199) != 0);
      if (!h_pend) begin
        host_req   = $urandom_range(0, 1) == 1;
        host_we    = $urandom_range(0, 1) == 1;
        host_addr  = 12'($urandom_range(0, 31));
        host_wdata = 8'($urandom);
      end
    end
    cpu_dbus_o = (cpu_ph == 0) ? fa[3:0] : (cpu_ph == 1) ? fa[7:4] :
                 (cpu_ph == 2) ? fa[11:8] : 4'($urandom);
    #1;
  endtask

  task automatic run_until(input int p);
    int n;
    n = 0;
    while (!(m_locked && !m_cpu_rst && m_phase == p) && n < 64) begin
      step();
      n++;
    end
    n_cmp++;
    assert (n < 64) else begin
      n_err++;
      $error("FAIL wait_phase%0d observed=timeout expected=locked phase within 64 cycles", p);
    end
  endtask

  task automatic host_write(input logic [11:0] a, input logic [7:0] d);
    host_req = 1; host_we = 1; host_addr = a; host_wdata = d;
    step();
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) begin
      logic [7:0] v;
      v = 8'($urandom);
      dev_mem[i] = v;
      ref_mem[i] = v;
    end
    rst_n = 0; cpu_run = 0; cpu_sync = 0; cpu_cm_rom = 1; cpu_dbus_o = 0;
    mem_rdata = 8'h00; host_req = 0; host_we = 0; host_addr = 0; host_wdata = 0;
    step(0);

    // reset: host owns the memory, CPU held
    host_req = 1; host_we = 0; host_addr = 12'h005;
    step(); step(); step();
    chk("rst_cpu_rst", cpu_rst, 1);
    chk("rst_gnt", host_gnt, 1);
    chk("rst_stall", stall_cnt, 0);
    chk("rst_dbus", cpu_dbus_i, 0);

    // program load, then first fetch from 0x000
    rst_n = 1;
    host_write(12'h000, 8'h20);
    host_write(12'h001, 8'h00);
    host_write(12'h0A5, 8'h3C);
    host_req = 0; cpu_run = 1; fa = 12'h000;
    run_until(2);
    chk("fetch_en", mem_en, 1);
    chk("fetch_addr", mem_addr, 12'h000);
    run_until(3);
    chk("fetch_opr", cpu_dbus_i, 4'h2);
    step();
    chk("fetch_opa", cpu_dbus_i, 4'h0);

    // host read in a non-slot cycle
    run_until(4);
    host_req = 1; host_we = 0; host_addr = 12'h0A5;
    step();
    host_req = 0;
    chk("rd_rvalid", host_rvalid, 1);
    chk("rd_rdata", host_rdata, 8'h3C);
    step();
    chk("rd_rvalid_drop", host_rvalid, 0);

    // continuous host request: one refusal per instruction cycle
    run_until(0);
    host_req = 1; host_we = 0; host_addr = 12'h010;
    repeat (32) step();
    host_req = 0;
    chk("stall_4", stall_cnt, 16'd4);

    // sync injected at M2
    run_until(4);
    cpu_sync = 1;
    step();
    chk("sync_err_set", sync_err, 1);
    step(); step();
    chk("realign_slot", mem_en, 1);
    repeat (8) step();
    chk("sync_err_sticky", sync_err, 1);

    // run drop mid-M1, then re-lock
    fa = 12'h0A5;
    run_until(7);
    run_until(3);
    chk("m1_opr_a5", cpu_dbus_i, 4'h3);
    cpu_run = 0;
    step();
    chk("hold_cpu_rst", cpu_rst, 1);
    chk("hold_dbus", cpu_dbus_i, 4'h0);
    repeat (5) step();
    cpu_run = 1;
    run_until(3);
    chk("relock_opr", cpu_dbus_i, 4'h3);
    step();
    chk("relock_opa", cpu_dbus_i, 4'hC);

    rnd_mode = 1;
    repeat (1500) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
